// File: rtl/reu_sdram_init_refresh_if.sv
// reu_sdram_init_refresh_if: SDRAM housekeeping bus between the init/refresh block (master) and the REU RAM block (slave)
interface reu_sdram_init_refresh_if;
    logic        PHI2;
    logic        AccessBusy;
    logic        Own;
    logic        Ready;
    logic [3:0]  Cmd;
    logic        CKE;
    logic [12:0] RA;
    logic [1:0]  RBA;
    logic        RefOverflow;
    modport master(input PHI2, AccessBusy, output Own, Ready, Cmd, CKE, RA, RBA, RefOverflow);
    modport slave(output PHI2, AccessBusy, input Own, Ready, Cmd, CKE, RA, RBA, RefOverflow);
endinterface

// File: rtl/reu_sdram_init_refresh.sv
// reu_sdram_init_refresh: SDRAM power-up init and periodic auto-refresh scheduler for the REU RAM block
// Outputs are registered from the next state, so Cmd/RA/Own change on the same edge the FSM moves.
module reu_sdram_init_refresh #(
    parameter int          INIT_WAIT      = 1600,
    parameter int          REF_INTERVAL   = 60,
    parameter int          INIT_REFRESHES = 8,
    parameter int          TRP_CYC        = 1,
    parameter int          TRFC_CYC       = 1,
    parameter int          TMRD_CYC       = 2,
    parameter logic [12:0] MODE_WORD      = 13'h220
) (
    input logic                      C8M,
    input logic                      nRESET,
    reu_sdram_init_refresh_if.master bus
);
    localparam logic [3:0] CmdDesel = 4'b1111;
    localparam logic [3:0] CmdNop   = 4'b0111;
    localparam logic [3:0] CmdPre   = 4'b0010;
    localparam logic [3:0] CmdRef   = 4'b0001;
    localparam logic [3:0] CmdMrs   = 4'b0000;
    localparam int CW = $clog2(INIT_WAIT + TRP_CYC + TRFC_CYC + TMRD_CYC + 1);
    localparam int TW = $clog2(REF_INTERVAL + 1);
    localparam logic [CW-1:0] InitLast = CW'(INIT_WAIT);
    localparam logic [CW-1:0] RpLast   = CW'(TRP_CYC - 1);
    localparam logic [CW-1:0] RfcLast  = CW'(TRFC_CYC - 1);
    localparam logic [CW-1:0] MrdLast  = CW'(TMRD_CYC - 1);
    localparam logic [TW-1:0] TickLast = TW'(REF_INTERVAL - 1);
    localparam logic [3:0]    RefsLast = 4'(INIT_REFRESHES);

    typedef enum logic [3:0] {
        stInitWait, stPreAll, stWaitRp, stInitRef, stInitRefWait,
        stLoadMode, stWaitMrd, stIdle, stGrant, stRef, stRefWait
    } state_t;

    state_t        state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [3:0]    refCnt, refCntNext;
    logic [TW-1:0] tickCnt;
    logic [2:0]    owed;
    logic          phi2Meta, phi2S;
    logic [3:0]    cmd, cmdNext;
    logic [12:0]   ra, raNext;
    logic          own, ready, cke, refOverflow;
    logic          window, tick, issue;

    assign window = state == stIdle && owed != 3'd0 && !phi2S && !bus.AccessBusy;
    assign tick   = ready && tickCnt == TickLast;
    assign issue  = state == stGrant;

    // Wait states are entered with cnt=0; INIT_WAIT alone counts from reset so its first edge is already a NOP.
    always_comb begin
        stateNext  = state;
        refCntNext = refCnt;
        case (state)
            stInitWait:    stateNext = cnt == InitLast ? stPreAll : stInitWait;
            stPreAll:      stateNext = stWaitRp;
            stWaitRp:      stateNext = cnt == RpLast ? stInitRef : stWaitRp;
            stInitRef: begin
                stateNext  = stInitRefWait;
                refCntNext = refCnt + 4'd1;
            end
            stInitRefWait: stateNext = cnt != RfcLast ? stInitRefWait : refCnt == RefsLast ? stLoadMode : stInitRef;
            stLoadMode:    stateNext = stWaitMrd;
            stWaitMrd:     stateNext = cnt == MrdLast ? stIdle : stWaitMrd;
            stIdle:        stateNext = window ? stGrant : stIdle;
            stGrant:       stateNext = stRef;
            stRef:         stateNext = stRefWait;
            stRefWait:     stateNext = cnt == RfcLast ? stIdle : stRefWait;
            default:       stateNext = stInitWait;
        endcase
        cntNext = stateNext == state ? cnt + 1'b1 : '0;
        cmdNext = stateNext == stPreAll ? CmdPre
                : (stateNext == stInitRef || stateNext == stRef) ? CmdRef
                : stateNext == stLoadMode ? CmdMrs : CmdNop;
        raNext  = stateNext == stPreAll ? 13'h400 : stateNext == stLoadMode ? MODE_WORD : 13'h0;
    end

    always_ff @(posedge C8M or negedge nRESET) begin
        if (!nRESET) begin
            state       <= stInitWait;
            cnt         <= '0;
            refCnt      <= '0;
            tickCnt     <= '0;
            owed        <= '0;
            phi2Meta    <= 1'b0;
            phi2S       <= 1'b0;
            cmd         <= CmdDesel;
            ra          <= '0;
            cke         <= 1'b0;
            own         <= 1'b1;
            ready       <= 1'b0;
            refOverflow <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            refCnt   <= refCntNext;
            phi2Meta <= bus.PHI2;
            phi2S    <= phi2Meta;
            cmd      <= cmdNext;
            ra       <= raNext;
            cke      <= 1'b1;
            own      <= stateNext != stIdle;
            ready    <= ready || stateNext == stIdle;
            if (ready)
                tickCnt <= tick ? '0 : tickCnt + 1'b1;
            // A tick and an issue on the same edge cancel; a tick on a full debt counter is lost.
            if (tick && !issue) begin
                if (owed == 3'd7)
                    refOverflow <= 1'b1;
                else
                    owed <= owed + 3'd1;
            end else if (issue && !tick)
                owed <= owed - 3'd1;
        end
    end

    assign bus.Cmd         = cmd;
    assign bus.CKE         = cke;
    assign bus.RA          = ra;
    assign bus.RBA         = 2'b00;
    assign bus.Own         = own;
    assign bus.Ready       = ready;
    assign bus.RefOverflow = refOverflow;
endmodule

// File: tb/tb_reu_sdram_init_refresh.sv
// tb_reu_sdram_init_refresh: directed bench for init sequence, refresh scheduling, backlog and reset
module tb_reu_sdram_init_refresh;
    localparam logic [3:0] DESEL = 4'hF, NOP = 4'h7, PRE = 4'h2, REF = 4'h1, MRS = 4'h0;

    typedef struct {
        logic        phi2;
        logic        busy;
        logic [3:0]  cmd;
        logic        own;
        logic        ready;
        logic        cke;
        logic [12:0] ra;
    } vec_t;

    logic C8M = 1'b0;
    logic nRESET = 1'b0;
    logic expOvf = 1'b0;
    int checks = 0;
    int passes = 0;
    vec_t initVec[20];

    reu_sdram_init_refresh_if bus();

    reu_sdram_init_refresh #(
        .INIT_WAIT(10), .REF_INTERVAL(20), .INIT_REFRESHES(2),
        .TRP_CYC(1), .TRFC_CYC(1), .TMRD_CYC(2), .MODE_WORD(13'h220)
    ) dut (
        .C8M(C8M),
        .nRESET(nRESET),
        .bus(bus)
    );

    always #5 C8M = ~C8M;

    task automatic compare(input string name, input logic [3:0] cmd, input logic own, input logic ready,
                           input logic cke, input logic [12:0] ra, input logic ovf);
        logic [22:0] act;
        logic [22:0] exp;
        act = {bus.Cmd, bus.Own, bus.Ready, bus.CKE, bus.RA, bus.RBA, bus.RefOverflow};
        exp = {cmd, own, ready, cke, ra, 2'b00, ovf};
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s @%0t: got cmd=%h own=%b ready=%b cke=%b ra=%h rba=%h ovf=%b, want cmd=%h own=%b ready=%b cke=%b ra=%h rba=0 ovf=%b",
                     name, $time, bus.Cmd, bus.Own, bus.Ready, bus.CKE, bus.RA, bus.RBA, bus.RefOverflow,
                     cmd, own, ready, cke, ra, ovf);
    endtask

    task automatic step(input string name, input logic [3:0] cmd, input logic own);
        @(posedge C8M);
        #1;
        compare(name, cmd, own, 1'b1, 1'b1, 13'h0, expOvf);
    endtask

    task automatic idleN(input string name, input int n);
        for (int i = 0; i < n; i++)
            step(name, NOP, 1'b0);
    endtask

    task automatic refSeq(input string name);
        step(name, NOP, 1'b1);
        step(name, REF, 1'b1);
        step(name, NOP, 1'b1);
    endtask

    task automatic runInit(input string name);
        for (int i = 0; i < 20; i++) begin
            bus.PHI2 = initVec[i].phi2;
            bus.AccessBusy = initVec[i].busy;
            @(posedge C8M);
            #1;
            compare(name, initVec[i].cmd, initVec[i].own, initVec[i].ready, initVec[i].cke, initVec[i].ra, 1'b0);
        end
    endtask

    initial begin
        // Edge k after release is entry k-1; PHI2/AccessBusy pulses mid-init must have no effect.
        for (int i = 0; i < 20; i++) begin
            initVec[i].phi2  = (i >= 2 && i <= 8);
            initVec[i].busy  = (i >= 4 && i <= 9);
            initVec[i].cmd   = NOP;
            initVec[i].own   = 1'b1;
            initVec[i].ready = 1'b0;
            initVec[i].cke   = 1'b1;
            initVec[i].ra    = 13'h0;
        end
        initVec[10].cmd = PRE;
        initVec[10].ra  = 13'h400;
        initVec[12].cmd = REF;
        initVec[14].cmd = REF;
        initVec[16].cmd = MRS;
        initVec[16].ra  = 13'h220;
        initVec[19].own   = 1'b0;
        initVec[19].ready = 1'b1;

        bus.PHI2 = 1'b0;
        bus.AccessBusy = 1'b0;
        repeat (3) @(posedge C8M);
        #1;
        compare("reset", DESEL, 1'b1, 1'b0, 1'b0, 13'h0, 1'b0);
        @(negedge C8M);
        nRESET = 1'b1;
        runInit("init");

        // Ticks land on edges 40, 60, 80 after release; REF follows two edges later.
        idleN("periodic", 20);
        refSeq("periodic ref1");
        idleN("periodic", 17);
        refSeq("periodic ref2");
        idleN("periodic", 17);
        refSeq("periodic ref3");
        idleN("periodic", 1);

        bus.PHI2 = 1'b1;
        idleN("phi2 gate", 21);
        bus.PHI2 = 1'b0;
        idleN("phi2 sync", 2);
        refSeq("phi2 fall ref");
        idleN("post phi2", 4);

        bus.AccessBusy = 1'b1;
        idleN("busy gate", 11);
        bus.AccessBusy = 1'b0;
        refSeq("busy drop ref");

        // Owed=1 from tick 140; release so the GRANT->REF edge lands on tick 160: owed stays 1.
        bus.PHI2 = 1'b1;
        idleN("hold debt", 28);
        bus.PHI2 = 1'b0;
        idleN("align sync", 2);
        refSeq("aligned ref");
        idleN("aligned gap", 1);
        refSeq("kept debt ref");
        idleN("debt cleared", 10);

        // Ticks 180..300 fill owed to 7, tick 320 overflows.
        bus.PHI2 = 1'b1;
        idleN("backlog", 144);
        expOvf = 1'b1;
        idleN("overflow", 1);
        bus.PHI2 = 1'b0;
        idleN("drain sync", 2);
        // Seven owed plus tick 340 (coincides with an issue, so it keeps one more) gives eight sequences.
        for (int k = 0; k < 8; k++) begin
            refSeq("drain ref");
            idleN("drain gap", 1);
        end
        idleN("drained", 6);
        step("pre-reset grant", NOP, 1'b1);
        step("pre-reset ref", REF, 1'b1);
        step("pre-reset wait", NOP, 1'b1);

        nRESET = 1'b0;
        #1;
        compare("async reset", DESEL, 1'b1, 1'b0, 1'b0, 13'h0, 1'b0);
        expOvf = 1'b0;
        @(negedge C8M);
        #1;
        compare("reset hold", DESEL, 1'b1, 1'b0, 1'b0, 13'h0, 1'b0);
        @(negedge C8M);
        nRESET = 1'b1;
        runInit("reinit");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/reu_sdram_init_refresh.md
Name: reu_sdram_init_refresh

Overview:
- C8M-domain SDRAM housekeeping stage that feeds the REU RAM block's SDRAM command bus.
- Performs the power-up init sequence: wait, precharge-all, N auto-refreshes, mode-register load.
- Then schedules periodic auto-refresh into PHI2-low windows, when the RAM block is idle.
- While Own=1, the RAM block muxes this block's command/address onto the SDRAM pins and holds off its own accesses.

Parameters:
- INIT_WAIT, 1600, C8M cycles of NOP after reset release (200 us at 8 MHz).
- REF_INTERVAL, 60, C8M cycles between refresh ticks (< 7.8 us).
- INIT_REFRESHES, 8, auto-refreshes issued during init.
- TRP_CYC, 1, NOP cycles after PRECHARGE.
- TRFC_CYC, 1, NOP cycles after each REFRESH.
- TMRD_CYC, 2, NOP cycles after MODE load.
- MODE_WORD, 13'h220, RA value at MODE load: BL1, sequential, CL2, single write.

Ports:
- C8M  in  1  system clock, 8 MHz; all state on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- PHI2  in  1  C64 phase; double-flop synchronised internally (PHI2s).
- AccessBusy  in  1  RAM block mid-access; no refresh may start while high.
- Own  out  1  this block owns the SDRAM command bus.
- Ready  out  1  init complete; RAM block may issue accesses.
- Cmd  out  4  {nCS,nRAS,nCAS,nRWE}.
- CKE  out  1  SDRAM clock enable.
- RA  out  13  SDRAM address.
- RBA  out  2  SDRAM bank.
- RefOverflow  out  1  sticky; a refresh debt was lost.

Behaviour:
- Command encodings:
  - DESEL 1111
  - NOP 0111
  - PRE 0010
  - REF 0001
  - MRS 0000
- Reset, asynchronous, nRESET low: Cmd=DESEL, CKE=0, RA=0, RBA=0, Own=1, Ready=0, RefOverflow=0, owed=0, state=INIT_WAIT, counters cleared.
- INIT_WAIT:
  - First edge after release: CKE=1, Cmd=NOP.
  - NOP held for INIT_WAIT cycles.
- PRE_ALL: 1 cycle, Cmd=PRE, RA[10]=1, other RA bits 0.
- WAIT_RP: TRP_CYC cycles of NOP.
- INIT_REF:
  - 1 cycle REF, then TRFC_CYC cycles of NOP.
  - Repeated INIT_REFRESHES times; a 4-bit counter tracks the repeats.
- LOAD_MODE: 1 cycle, Cmd=MRS, RA=MODE_WORD, RBA=0.
- WAIT_MRD: TMRD_CYC cycles of NOP.
- On exit to IDLE (same edge): Ready=1, Own=0, Cmd=NOP. Ready then stays 1 until reset.
- Refresh tick counter:
  - Free-runs from IDLE entry.
  - Every REF_INTERVAL cycles it pulses a tick and reloads.
- owed (3-bit debt counter):
  - tick alone: owed+1.
  - issue alone: owed-1.
  - tick and issue on the same edge: owed unchanged.
  - tick with owed=7 and no issue: owed stays 7, RefOverflow set (sticky until reset).
- Refresh window: state=IDLE && owed>0 && PHI2s==0 && AccessBusy==0.
- Refresh sequence from IDLE when the window is true:
  - GRANT: 1 cycle, Own=1, Cmd=NOP. Lets the RAM block mux switch.
  - REF: 1 cycle, Cmd=REF; the issue event decrements owed.
  - REF_WAIT: TRFC_CYC NOP cycles.
  - Back to IDLE: Own=0 on the edge entering IDLE.
- No abort once GRANT is entered, even if PHI2s or AccessBusy rises. The RAM block must honour Own.
- Back-to-back refreshes: from IDLE a new GRANT may start on the next edge if the window is still true. Minimum 1 IDLE cycle between sequences.
- Latency, refresh window true to REF on Cmd: 2 edges.
- RA/RBA are 0 in every state except PRE_ALL and LOAD_MODE.
- Reset mid-sequence, any state: immediately returns to the reset values and re-runs full init.
- No ticks are counted before Ready.

Test Plan:
- Init sequence (INIT_WAIT=10, INIT_REFRESHES=2, TRP/TRFC=1, TMRD=2): release nRESET.
  - Cycle 1 CKE=1 and NOP ×10.
  - Then PRE with RA=13'h400, NOP.
  - Then REF, NOP, REF, NOP.
  - Then MRS with RA=13'h220.
  - Then NOP ×2, Ready=1, Own=0.
- Periodic refresh (REF_INTERVAL=20, PHI2 held low, AccessBusy=0): REF appears 2 cycles after each tick. Ticks occur every 20 cycles; Own is high for 3 cycles per refresh; owed returns to 0.
- Window gating: tick while PHI2=1 → no GRANT. PHI2 falls → REF on Cmd 4 edges later (2 sync + GRANT + REF). Same result with AccessBusy=1 until it drops.
- Backlog and overflow: hold PHI2=1 for 8 ticks → owed saturates at 7 and RefOverflow=1. Release → 7 REF sequences, each separated by ≥1 IDLE cycle; RefOverflow stays 1.
- Simultaneous tick and issue: align a tick with the REF cycle → owed unchanged across that edge.
- Reset mid-refresh: assert nRESET during REF_WAIT → Cmd=DESEL, CKE=0, Own=1, Ready=0 asynchronously. After release the full init re-runs.
